// File: rtl/reg_file_sb.sv
// Register file for the pipelined datapath.
// It has 2 read ports and 1 write port, a per-register pending (scoreboard) bit,
// write-to-read bypass, an optional hardwired zero register, and a running count
// of outstanding writes.
module reg_file_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W:0]   pend_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic [DEPTH-1:0]  w_pend_d;
  logic [ADDR_W:0]   r_pend_count;
  logic [ADDR_W:0]   w_cnt_d;

  logic w_rs1_zero, w_rs2_zero, w_wb_zero, w_iss_zero;
  logic w_rs1_byp, w_rs2_byp;
  logic w_set_hit, w_clr_hit, w_inc, w_dec;

  assign w_rs1_zero = (ZERO_REG != 0) && (rs1_addr == '0);
  assign w_rs2_zero = (ZERO_REG != 0) && (rs2_addr == '0);
  assign w_wb_zero  = (ZERO_REG != 0) && (wb_addr == '0);
  assign w_iss_zero = (ZERO_REG != 0) && (issue_rd == '0);

  // Bypass is suppressed during reset because the writeback is being discarded.
  assign w_rs1_byp = (BYPASS != 0) && !reset && RegWrite && (wb_addr == rs1_addr) && !w_rs1_zero;
  assign w_rs2_byp = (BYPASS != 0) && !reset && RegWrite && (wb_addr == rs2_addr) && !w_rs2_zero;

  assign w_set_hit = issue_valid && !w_iss_zero;
  assign w_clr_hit = RegWrite && r_pend[wb_addr] && !w_wb_zero;
  // Count only a fresh set. A clear that a same-address issue overrides is not counted.
  assign w_inc     = w_set_hit && !r_pend[issue_rd];
  assign w_dec     = w_clr_hit && !(w_set_hit && (issue_rd == wb_addr));

  assign pend_count = r_pend_count;

  // Read muxes: the zero register comes first, then bypass, then stored data.
  always_comb begin
    rs1_data = r_regs[rs1_addr];
    rs2_data = r_regs[rs2_addr];
    if (w_rs1_zero) begin
      rs1_data = '0;
    end else if (w_rs1_byp) begin
      rs1_data = wb_data;
    end
    if (w_rs2_zero) begin
      rs2_data = '0;
    end else if (w_rs2_byp) begin
      rs2_data = wb_data;
    end
    rs1_busy = !reset && r_pend[rs1_addr] && !w_rs1_byp;
    rs2_busy = !reset && r_pend[rs2_addr] && !w_rs2_byp;
  end

  // Next pending vector: apply the clear first so that a same-address issue wins.
  always_comb begin
    w_pend_d = r_pend;
    if (w_clr_hit) begin
      w_pend_d[wb_addr] = 1'b0;
    end
    if (w_set_hit) begin
      w_pend_d[issue_rd] = 1'b1;
    end
    w_cnt_d = r_pend_count + (ADDR_W + 1)'(w_inc) - (ADDR_W + 1)'(w_dec);
  end

  // Register storage write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (RegWrite && !w_wb_zero) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Scoreboard state and the incremental outstanding-write count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend       <= '0;
      r_pend_count <= '0;
    end else begin
      r_pend       <= w_pend_d;
      r_pend_count <= w_cnt_d;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed and random-traffic bench for reg_file_sb.
// It has a default instance and a second instance with no bypass and no zero register.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb_addr;
  logic [31:0] wb_data;
  logic        issue_valid, RegWrite;

  logic [31:0] rs1_data, rs2_data, nb_rs1_data, nb_rs2_data;
  logic        rs1_busy, rs2_busy, nb_rs1_busy, nb_rs2_busy;
  logic [5:0]  pend_count, nb_pend_count;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  reg_file_sb u_dut (
    .clk        (clk),
    .reset      (reset),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .RegWrite   (RegWrite),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .pend_count (pend_count)
  );

  reg_file_sb #(
    .ZERO_REG(0),
    .BYPASS  (0)
  ) u_dut_nb (
    .clk        (clk),
    .reset      (reset),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (nb_rs1_data),
    .rs2_data   (nb_rs2_data),
    .rs1_busy   (nb_rs1_busy),
    .rs2_busy   (nb_rs2_busy),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .RegWrite   (RegWrite),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .pend_count (nb_pend_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    RegWrite    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
  endtask

  // Reference state for the default instance (ZERO_REG=1, BYPASS=1).
  logic [31:0] m_regs [32];
  logic [31:0] m_pend;
  int          order [31];
  int          j, tmp, pc;
  logic [31:0] exp_d;

  initial begin
    reset = 1'b1; rs1_addr = '0; rs2_addr = '0; issue_rd = '0; wb_addr = '0; wb_data = '0;
    issue_valid = 1'b0; RegWrite = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset test: fill the registers, make one pending, then reset with traffic applied.
    for (int i = 1; i < 32; i++) begin
      RegWrite = 1'b1; wb_addr = 5'(i); wb_data = 32'hA5A5_0000 + 32'(i);
      tick();
    end
    idle();
    issue_valid = 1'b1; issue_rd = 5'd4;
    tick();
    idle();
    rs1_addr = 5'd3;
    #1;
    check("pre_rst_rd3", rs1_data, 32'hA5A5_0003);
    reset = 1'b1; issue_valid = 1'b1; issue_rd = 5'd6;
    RegWrite = 1'b1; wb_addr = 5'd7; wb_data = 32'hFFFF_FFFF;
    rs1_addr = 5'd4; rs2_addr = 5'd7;
    #1;
    check("rst_busy_forced", rs1_busy, 0);
    check("rst_stored_rd4", rs1_data, 32'hA5A5_0004);
    check("rst_no_bypass", rs2_data, 32'hA5A5_0007);
    tick();
    reset = 1'b0;
    idle();
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      #1;
      check("rst_rs1_zero", rs1_data, 0);
      check("rst_rs2_zero", rs2_data, 0);
      check("rst_rs1_busy", rs1_busy, 0);
    end
    check("rst_count", pend_count, 0);
    check("rst_count_nb", nb_pend_count, 0);

    // Zero register: write and issue to r0 in the same cycle.
    RegWrite = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
    issue_valid = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0;
    #1;
    check("zero_same_cycle", rs1_data, 0);
    tick();
    idle();
    check("zero_rd", rs1_data, 0);
    check("zero_busy", rs1_busy, 0);
    check("zero_count", pend_count, 0);
    check("nb_r0_rd", nb_rs1_data, 32'hDEAD_BEEF);
    check("nb_r0_busy", nb_rs1_busy, 1);
    check("nb_r0_count", nb_pend_count, 1);
    RegWrite = 1'b1; wb_addr = 5'd0; wb_data = 32'h0;
    tick();
    idle();
    check("nb_r0_clr_count", nb_pend_count, 0);

    // Bypass: same-cycle forward on the default instance, next cycle on the no-bypass one.
    RegWrite = 1'b1; wb_addr = 5'd5; wb_data = 32'h11;
    tick();
    RegWrite = 1'b1; wb_addr = 5'd5; wb_data = 32'h22; rs1_addr = 5'd5; rs2_addr = 5'd5;
    #1;
    check("byp_rs1", rs1_data, 32'h22);
    check("byp_rs2", rs2_data, 32'h22);
    check("nb_byp_rs1_old", nb_rs1_data, 32'h11);
    check("nb_byp_rs2_old", nb_rs2_data, 32'h11);
    tick();
    idle();
    check("nb_byp_rs1_new", nb_rs1_data, 32'h22);
    check("byp_rs1_after", rs1_data, 32'h22);

    // Scoreboard: issue 7 twice, then write it back with bypass.
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle();
    rs1_addr = 5'd7;
    #1;
    check("sb_busy", rs1_busy, 1);
    check("sb_count1", pend_count, 1);
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle();
    check("sb_waw_count", pend_count, 1);
    check("sb_waw_count_nb", nb_pend_count, 1);
    RegWrite = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    #1;
    check("sb_byp_busy", rs1_busy, 0);
    check("sb_byp_data", rs1_data, 32'h77);
    check("nb_sb_busy", nb_rs1_busy, 1);
    tick();
    idle();
    check("sb_wb_busy", rs1_busy, 0);
    check("sb_wb_count", pend_count, 0);
    check("nb_sb_wb_count", nb_pend_count, 0);

    // Collision: issue and writeback to a pending register in the same cycle.
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b1; issue_rd = 5'd9; RegWrite = 1'b1; wb_addr = 5'd9; wb_data = 32'h33;
    tick();
    idle();
    rs1_addr = 5'd9;
    #1;
    check("col_data", rs1_data, 32'h33);
    check("col_busy", rs1_busy, 1);
    check("col_count", pend_count, 1);
    check("col_count_nb", nb_pend_count, 1);

    // Saturation: issue every non-zero register, then retire them in shuffled order.
    for (int i = 1; i < 32; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i);
      tick();
    end
    idle();
    check("sat_full", pend_count, 31);
    check("sat_full_nb", nb_pend_count, 31);
    for (int k = 0; k < 31; k++) order[k] = k + 1;
    for (int k = 30; k > 0; k--) begin
      j = int'($urandom_range(k, 0));
      tmp = order[k]; order[k] = order[j]; order[j] = tmp;
    end
    for (int k = 0; k < 31; k++) begin
      RegWrite = 1'b1; wb_addr = 5'(order[k]); wb_data = $urandom;
      tick();
      check("sat_drain", pend_count, 6'(30 - k));
    end
    RegWrite = 1'b1; wb_addr = 5'd3; wb_data = 32'h5;
    tick();
    idle();
    check("sat_no_underflow", pend_count, 0);

    // Random traffic against a reference model of the default instance.
    do_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pend = '0;
    for (int c = 0; c < 10000; c++) begin
      issue_valid = 1'($urandom_range(1, 0)); issue_rd = 5'($urandom_range(31, 0));
      RegWrite = 1'($urandom_range(1, 0)); wb_addr = 5'($urandom_range(31, 0));
      wb_data = $urandom;
      rs1_addr = 5'($urandom_range(31, 0)); rs2_addr = 5'($urandom_range(31, 0));
      #1;
      exp_d = (rs1_addr == 0) ? 32'h0 : (RegWrite && wb_addr == rs1_addr) ? wb_data
            : m_regs[rs1_addr];
      check("rnd_rs1_data", rs1_data, exp_d);
      check("rnd_rs1_busy", rs1_busy,
            (rs1_addr != 0) && m_pend[rs1_addr] && !(RegWrite && wb_addr == rs1_addr));
      exp_d = (rs2_addr == 0) ? 32'h0 : (RegWrite && wb_addr == rs2_addr) ? wb_data
            : m_regs[rs2_addr];
      check("rnd_rs2_data", rs2_data, exp_d);
      check("rnd_rs2_busy", rs2_busy,
            (rs2_addr != 0) && m_pend[rs2_addr] && !(RegWrite && wb_addr == rs2_addr));
      @(posedge clk);
      if (RegWrite && wb_addr != 0) begin
        m_regs[wb_addr] = wb_data;
        m_pend[wb_addr] = 1'b0;
      end
      if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      #1;
      pc = 0;
      for (int b = 0; b < 32; b++) pc += int'(m_pend[b]);
      check("rnd_count", pend_count, 64'(pc));
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor of the single-cycle CPU register file, for the pipelined datapath. It keeps the 2-read/1-write storage and adds a per-register pending (scoreboard) bit set at issue and cleared at writeback. It also adds write-to-read bypass, an optional hardwired zero register and a running count of outstanding writes. It sits between decode/issue (read and issue side) and writeback.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
ZERO_REG, 1, 1: register 0 reads 0, ignores writes and never becomes pending; 0: register 0 is ordinary
BYPASS, 1, 1: same-cycle writeback data is forwarded to the read ports; 0: reads return stored value only

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
rs1_addr  input  ADDR_W  read port 1 address
rs2_addr  input  ADDR_W  read port 2 address
rs1_data  output  DATA_W  read port 1 data (combinational)
rs2_data  output  DATA_W  read port 2 data (combinational)
rs1_busy  output  1  register rs1_addr has an outstanding write
rs2_busy  output  1  register rs2_addr has an outstanding write
issue_valid  input  1  an instruction writing issue_rd issues this cycle
issue_rd  input  ADDR_W  destination register of the issuing instruction
RegWrite  input  1  writeback enable
wb_addr  input  ADDR_W  writeback register
wb_data  input  DATA_W  writeback data
pend_count  output  ADDR_W+1  number of pending bits currently set

Behaviour:
- State: regs[0..2**ADDR_W-1] of DATA_W bits, pending[0..2**ADDR_W-1], and a pend_count register.
- Reset (reset=1 at a rising edge): all regs cleared to 0, all pending bits cleared to 0, pend_count cleared to 0. Issue and writeback in the same cycle are ignored.
- While reset=1: bypass and busy outputs are forced inactive. rs*_data shows stored contents (0 from the cycle after the reset edge onward).
- Write: on a rising edge with RegWrite=1 and reset=0, regs[wb_addr] <= wb_data. With ZERO_REG=1, writes to address 0 are discarded.
- Read: rs*_data = regs[rs*_addr], with these overrides:
  - With ZERO_REG=1 and rs*_addr=0, the output is 0.
  - With BYPASS=1, RegWrite=1 and wb_addr=rs*_addr (and not the zero register), the output is wb_data in the same cycle. Zero latency.
- Busy: rs*_busy = pending[rs*_addr], except it is 0 when a same-cycle writeback to that address is bypassed (BYPASS=1). With BYPASS=0, busy reflects pending only.
- Pending update per edge (reset=0), evaluated from the current state:
  - set_hit = issue_valid and the target is not the zero register.
  - clr_hit = RegWrite and pending[wb_addr] and the target is not the zero register.
  - If issue_rd = wb_addr and both are active, issue wins: pending stays 1 and the data is still written.
  - A writeback to a non-pending register writes data but does not change pending or pend_count.
  - An issue to an already-pending register leaves pending 1 (WAW); it is not counted twice.
- pend_count: next = count + (set_hit and the target was not pending) - (clr_hit and not overridden by an issue to the same address). It never exceeds the depth and never underflows. It always equals the popcount of pending, and the implementation must use the incremental update above.
- The block does not stall anything itself. The consumer uses rs*_busy.

Test Plan:
- Reset: write regs 1..31 with 0xA5A5_0000+i, assert reset 1 cycle -> all rs*_data=0, busy=0, pend_count=0 on the next cycle.
- Zero reg (ZERO_REG=1): RegWrite wb_addr=0 wb_data=0xDEADBEEF, issue_rd=0 -> rs1_addr=0 reads 0, rs1_busy=0, pend_count unchanged.
- Bypass: regs[5]=0x11; RegWrite wb_addr=5 wb_data=0x22 with rs1_addr=rs2_addr=5 -> both outputs read 0x22 in the same cycle. With BYPASS=0 they read 0x11, then 0x22 the next cycle.
- Scoreboard: issue rd=7 -> rs1_busy(7)=1 and pend_count=1 the next cycle. Issue rd=7 again -> pend_count stays 1. Writeback 7 -> busy=0 and pend_count=0.
- Collision: pending[9]=1, same cycle issue rd=9 and writeback 9 data=0x33 -> regs[9]=0x33, pending[9] stays 1, pend_count unchanged.
- Saturation: issue all 31 non-zero registers back to back -> pend_count=31. Then write back all of them in random order -> pend_count decrements to 0 with no underflow; a random-traffic check of pend_count against the popcount of pending passes over 10k cycles.
